// File: rtl/lix_pipe_rv_pkg.sv
// Shared helpers for the elastic valid/ready pipeline.
package lix_pkg;

  // Width of an occupancy counter that must represent 0..n inclusive.
  function automatic int unsigned clog2_n1(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/lix_pipe_rv_if.sv
// Upstream/downstream handshake bundle for lix_pipe_rv; master drives the pipeline.
interface lix_pipe_rv_if #(
  parameter int unsigned W = 32
);
  logic         i_vld;
  logic         o_rdy;
  logic [W-1:0] i_x;
  logic         i_flush;
  logic         o_vld;
  logic         i_rdy;
  logic [W-1:0] o_z;

  modport master (
    output i_vld, i_x, i_flush, i_rdy,
    input  o_rdy, o_vld, o_z
  );

  modport slave (
    input  i_vld, i_x, i_flush, i_rdy,
    output o_rdy, o_vld, o_z
  );
endinterface

// File: rtl/lix_pipe_rv_stage.sv
// One elastic stage: a valid bit plus a data register that loads only on valid beats.
module lix_pipe_stage #(
  parameter int unsigned W = 32
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         i_vld,
  input  logic         i_rdy_dn,
  input  logic         i_flush,
  output logic         o_vld,
  output logic         o_rdy_up,
  input  logic [W-1:0] i_x,
  output logic [W-1:0] o_z
);

  logic         v_q, v_d;
  logic [W-1:0] d_q, d_d;

  always_comb begin
    o_rdy_up = !v_q || i_rdy_dn;
    v_d      = v_q;
    d_d      = d_q;
    if (i_flush) begin
      v_d = 1'b0;
    end else if (o_rdy_up) begin
      v_d = i_vld;
      if (i_vld) begin
        d_d = i_x;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      v_q <= 1'b0;
      d_q <= '0;
    end else begin
      v_q <= v_d;
      d_q <= d_d;
    end
  end

  assign o_vld = v_q;
  assign o_z   = d_q;

endmodule

// File: rtl/lix_pipe_rv.sv
// N-stage, W-bit elastic pipeline with combinational ready chain, bubble collapse and flush.
module lix_pipe_rv
  import lix_pkg::*;
#(
  parameter int unsigned W = 32,
  parameter int unsigned N = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  lix_pipe_rv_if.slave           bus,
  output logic [clog2_n1(N)-1:0] o_cnt,
  output logic                   o_full,
  output logic                   o_empty
);

  localparam int unsigned CW = clog2_n1(N);

  logic [N-1:0] vld_s;
  logic [W-1:0] dat_s [N];
  logic         up_xfer, dn_xfer;
  logic [CW-1:0] cnt_q, cnt_d;

  // Each stage keeps its ready in a block-local net so the ready chain is a
  // set of distinct signals rather than one vector depending on itself.
  for (genvar k = 0; k < N; k++) begin : g_stg
    logic         rdy_up;
    logic         rdy_dn;
    logic         vld_in;
    logic [W-1:0] x_in;

    if (k == N - 1) begin : g_last
      assign rdy_dn = bus.i_rdy;
    end else begin : g_mid
      assign rdy_dn = g_stg[k+1].rdy_up;
    end

    if (k == 0) begin : g_first
      assign vld_in = bus.i_vld;
      assign x_in   = bus.i_x;
    end else begin : g_link
      assign vld_in = vld_s[k-1];
      assign x_in   = dat_s[k-1];
    end

    lix_pipe_stage #(.W(W)) u_stage (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .i_vld    (vld_in),
      .i_rdy_dn (rdy_dn),
      .i_flush  (bus.i_flush),
      .o_vld    (vld_s[k]),
      .o_rdy_up (rdy_up),
      .i_x      (x_in),
      .o_z      (dat_s[k])
    );
  end

  assign bus.o_rdy = g_stg[0].rdy_up && !bus.i_flush;
  assign bus.o_vld = vld_s[N-1] && !bus.i_flush;
  assign bus.o_z   = dat_s[N-1];

  assign up_xfer = bus.i_vld && bus.o_rdy;
  assign dn_xfer = bus.o_vld && bus.i_rdy;

  // Tracking transfers equals the popcount of the next valid vector, without an adder tree.
  always_comb begin
    cnt_d = cnt_q + CW'(up_xfer) - CW'(dn_xfer);
    if (bus.i_flush) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_cnt   = cnt_q;
  assign o_full  = (cnt_q == CW'(N));
  assign o_empty = (cnt_q == '0);

endmodule

// File: tb/tb_lix_pipe_rv.sv
// Directed and scoreboard-checked bench for lix_pipe_rv at N=3 and N=4.
module tb_lix_pipe_rv;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  lix_pipe_rv_if #(.W(32)) b3 ();
  lix_pipe_rv_if #(.W(32)) b4 ();

  logic [1:0] cnt3;
  logic [2:0] cnt4;
  logic       full3, empty3, full4, empty4;

  lix_pipe_rv #(.W(32), .N(3)) u3 (
    .clk_i   (clk),
    .rst_i   (rst),
    .bus     (b3.slave),
    .o_cnt   (cnt3),
    .o_full  (full3),
    .o_empty (empty3)
  );

  lix_pipe_rv #(.W(32), .N(4)) u4 (
    .clk_i   (clk),
    .rst_i   (rst),
    .bus     (b4.slave),
    .o_cnt   (cnt4),
    .o_full  (full4),
    .o_empty (empty4)
  );

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic drive3(input logic vld, input logic [31:0] x, input logic rdy, input logic fl);
    b3.i_vld = vld; b3.i_x = x; b3.i_rdy = rdy; b3.i_flush = fl;
  endtask

  task automatic drive4(input logic vld, input logic [31:0] x, input logic rdy, input logic fl);
    b4.i_vld = vld; b4.i_x = x; b4.i_rdy = rdy; b4.i_flush = fl;
  endtask

  // Expected o_rdy/o_full per cycle for a 5-cycle stall at N=3 starting empty.
  logic bp_rdy  [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
  logic bp_full [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

  logic [31:0] q [$];
  logic        r_vld, r_rdy, r_fl, exp_rdy;
  logic [31:0] r_x;
  logic [31:0] exp_z;

  initial begin
    // Reset with junk on the inputs
    rst = 1'b1;
    drive3(1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0);
    drive4(1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0);
    tick();
    tick();
    rst = 1'b0;
    drive3(1'b1, 32'h55, 1'b1, 1'b0);
    drive4(1'b0, '0, 1'b1, 1'b0);
    settle();
    chk("rst_vld", b3.o_vld, 0);
    chk("rst_z", b3.o_z, 0);
    chk("rst_cnt", cnt3, 0);
    chk("rst_empty", empty3, 1);
    chk("rst_full", full3, 0);
    chk("rst_rdy", b3.o_rdy, 1);
    chk("rst_z4", b4.o_z, 0);
    chk("rst_empty4", empty4, 1);
    tick();
    drive3(1'b0, '0, 1'b1, 1'b0);
    for (int unsigned c = 1; c <= 3; c++) begin
      settle();
      chk("lat_vld", b3.o_vld, (c == 3) ? 1 : 0);
      if (c == 3) chk("lat_z", b3.o_z, 32'h55);
      tick();
    end

    // Streaming 0x1..0x8 at N=3
    for (int unsigned c = 0; c <= 11; c++) begin
      drive3(c < 8, (c < 8) ? 32'(c + 1) : '0, 1'b1, 1'b0);
      settle();
      if (c < 8) chk("str_rdy", b3.o_rdy, 1);
      chk("str_vld", b3.o_vld, (c >= 3 && c <= 10) ? 1 : 0);
      if (c >= 3 && c <= 10) chk("str_z", b3.o_z, 64'(c - 2));
      tick();
    end

    // Backpressure: 5 stalled cycles while offering 0x11..0x15
    for (int unsigned c = 0; c < 5; c++) begin
      drive3(1'b1, 32'(32'h11 + c), 1'b0, 1'b0);
      settle();
      chk("bp_rdy", b3.o_rdy, 64'(bp_rdy[c]));
      chk("bp_full", full3, 64'(bp_full[c]));
      if (c >= 3) begin
        chk("bp_hold_z", b3.o_z, 32'h11);
        chk("bp_hold_vld", b3.o_vld, 1);
        chk("bp_cnt", cnt3, 3);
      end
      tick();
    end
    for (int unsigned c = 0; c < 4; c++) begin
      drive3(1'b0, '0, 1'b1, 1'b0);
      settle();
      chk("bp_drain_vld", b3.o_vld, (c < 3) ? 1 : 0);
      if (c < 3) chk("bp_drain_z", b3.o_z, 64'(32'h11 + c));
      tick();
    end

    // Bubble collapse at N=4
    for (int unsigned c = 0; c <= 9; c++) begin
      drive4(c == 0 || c == 3, (c == 0) ? 32'hA : 32'hB, !(c >= 4 && c <= 6), 1'b0);
      settle();
      if (c >= 4 && c <= 6) begin
        chk("bub_rdy", b4.o_rdy, 1);
        chk("bub_cnt", cnt4, 2);
        chk("bub_z", b4.o_z, 32'hA);
      end
      if (c == 7) chk("bub_first", b4.o_z, 32'hA);
      if (c == 8) begin
        chk("bub_second_vld", b4.o_vld, 1);
        chk("bub_second", b4.o_z, 32'hB);
      end
      if (c == 9) chk("bub_empty", cnt4, 0);
      tick();
    end

    // Flush a full pipeline while offering 0xDD
    for (int unsigned c = 0; c < 3; c++) begin
      drive3(1'b1, 32'(32'hC0 + c), 1'b0, 1'b0);
      tick();
    end
    drive3(1'b1, 32'hDD, 1'b1, 1'b1);
    settle();
    chk("fl_full", full3, 1);
    chk("fl_vld", b3.o_vld, 0);
    chk("fl_rdy", b3.o_rdy, 0);
    tick();
    drive3(1'b0, '0, 1'b1, 1'b0);
    settle();
    chk("fl_cnt", cnt3, 0);
    chk("fl_empty", empty3, 1);
    chk("fl_rdy_after", b3.o_rdy, 1);
    for (int unsigned c = 0; c < 4; c++) begin
      settle();
      chk("fl_no_dd", b3.o_vld, 0);
      tick();
    end

    // Randomised cross-check against a queue scoreboard
    q.delete();
    for (int unsigned c = 0; c < 10008; c++) begin
      if (c < 10000) begin
        r_vld = ($urandom_range(0, 1) == 1);
        r_rdy = ($urandom_range(0, 9) < 6);
        r_fl  = ($urandom_range(0, 31) == 0);
        r_x   = $urandom;
      end else begin
        r_vld = 1'b0; r_rdy = 1'b1; r_fl = 1'b0; r_x = '0;
      end
      drive3(r_vld, r_x, r_rdy, r_fl);
      settle();
      exp_rdy = !r_fl && (q.size() < 3 || r_rdy);
      chk("rnd_cnt", cnt3, 64'(q.size()));
      chk("rnd_rdy", b3.o_rdy, 64'(exp_rdy));
      if (r_fl || q.size() == 0) chk("rnd_vld_lo", b3.o_vld, 0);
      else if (q.size() == 3) chk("rnd_vld_hi", b3.o_vld, 1);
      if (r_fl) begin
        q.delete();
      end else begin
        if (b3.o_vld && r_rdy && q.size() != 0) begin
          exp_z = q.pop_front();
          chk("rnd_z", b3.o_z, 64'(exp_z));
        end
        if (r_vld && exp_rdy) q.push_back(r_x);
      end
      tick();
    end
    settle();
    chk("rnd_end_cnt", cnt3, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
